sysid_verify_master: RTL



---
 rtl/sysid_verify_pkg.sv | 34 +++
 rtl/sysid_read_txn.sv | 68 ++++++
 rtl/sysid_verify_master.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_verify_pkg.sv
// -----------------------------------------------------------------------------
// sysid_verify_pkg
// Shared definitions for the system-ID verify master:
//   - state_t     : top-level sequencing states (3-bit encoding)
//   - ADDR_ID/TS  : word addresses of the system-ID slave
//   - MAX_RETRIES : retry limit used when SYSID_VERIFY_RETRY_EN is defined
// -----------------------------------------------------------------------------
package sysid_verify_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int unsigned MAX_RETRIES = 3;

  // True while a read is in flight (request or response phase).
  function automatic logic is_read_state(input state_t s);
    return (s == ID_REQ) || (s == ID_WAIT) || (s == TS_REQ) || (s == TS_WAIT);
  endfunction

  // True while the read request is being presented on the bus.
  function automatic logic is_req_state(input state_t s);
    return (s == ID_REQ) || (s == TS_REQ);
  endfunction

endpackage

// File: rtl/sysid_read_txn.sv
// -----------------------------------------------------------------------------
// sysid_read_txn
// One Avalon-MM read: request handshake decode, response capture strobe and
// the per-read timeout counter. The owning FSM says which phase it is in; this
// block says what happened on the bus this cycle.
//
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed per read (>= 2)
//   CNT_W          : counter width, 2**CNT_W >= TIMEOUT_CYCLES
// Ports:
//   clock, reset_n     : clock, synchronous active-low reset
//   i_clear            : a REQ state is being entered this edge
//   i_active           : owner is in a REQ or WAIT state
//   i_req              : owner is in a REQ state (avm_read asserted)
//   avm_waitrequest    : slave stall
//   avm_readdatavalid  : response strobe
//   avm_readdata       : response data
//   o_accept           : request accepted this cycle
//   o_valid            : response captured this cycle
//   o_timeout          : read expired this cycle without a response
//   o_data             : response data to capture
// -----------------------------------------------------------------------------
module sysid_read_txn
  import sysid_verify_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_active,
  input  logic        i_req,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        o_accept,
  output logic        o_valid,
  output logic        o_timeout,
  output logic [31:0] o_data
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter value seen in cycle k after REQ entry is k, so the read expires
  // on the TIMEOUT_CYCLES-th edge after entry.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || !i_active) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_accept  = i_req & ~avm_waitrequest;
  // Strobes outside a read are dropped here, so IDLE/DONE never capture.
  assign o_valid   = i_active & avm_readdatavalid;
  // A response on the expiry cycle wins over the timeout.
  assign o_timeout = i_active & (r_cnt == LAST_CNT) & ~o_valid;
  assign o_data    = avm_readdata;

endmodule

// File: rtl/sysid_verify_master.sv
// -----------------------------------------------------------------------------
// sysid_verify_master
// Avalon-MM read master that, on a start pulse, reads word 0 (system ID) and
// word 1 (build timestamp) from the system-ID slave, compares them against the
// expected constants and reports the result to boot/status logic.
//
// Optional feature macro: SYSID_VERIFY_RETRY_EN
//   Defined   : a failing or timed-out sequence restarts from ID_REQ up to
//               MAX_RETRIES times; retry_cnt output reports retries taken.
//   Undefined : single pass, no retry_cnt port.
//
// Parameters:
//   EXPECTED_ID, EXPECTED_TIMESTAMP : reference values for words 0 and 1
//   TIMEOUT_CYCLES (>= 2), CNT_W (2**CNT_W >= TIMEOUT_CYCLES)
// Ports:
//   clock, reset_n     : clock, synchronous active-low reset
//   start              : single-cycle pulse, ignored while busy
//   avm_*              : Avalon-MM read master interface
//   busy               : sequence in progress
//   done               : sequence finished, held until next start
//   id_ok, ts_ok       : captured word matched its expected value
//   timeout            : a read expired before its response
//   id_value, ts_value : captured words
//   retry_cnt          : retries taken (SYSID_VERIFY_RETRY_EN only)
//
// Timing with a zero-wait slave and readdatavalid one cycle after acceptance:
// start sampled on edge 1, done visible after edge 5.
// -----------------------------------------------------------------------------
module sysid_verify_master
  import sysid_verify_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1417485996,
  parameter int unsigned TIMEOUT_CYCLES     = 256,
  parameter int unsigned CNT_W              = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
`ifdef SYSID_VERIFY_RETRY_EN
  ,
  output logic [1:0]  retry_cnt
`endif
);

  state_t      r_state;
  state_t      w_next;

  logic        w_active;
  logic        w_in_req;
  logic        w_accept;
  logic        w_valid;
  logic        w_expire;
  logic [31:0] w_data;

  logic        w_start;
  logic        w_cap_id;
  logic        w_cap_ts;
  logic        w_set_to;
  logic        w_end;
  logic        w_enter_req;
  logic        w_clear;
  logic        w_id_match;
  logic        w_ts_match;

  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

`ifdef SYSID_VERIFY_RETRY_EN
  logic        w_fail;
  logic        w_retry;
  logic [1:0]  r_retry_cnt;
`endif

  assign w_active = is_read_state(r_state);
  assign w_in_req = is_req_state(r_state);

  sysid_read_txn #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_txn (
    .clock             (clock),
    .reset_n           (reset_n),
    .i_clear           (w_enter_req),
    .i_active          (w_active),
    .i_req             (w_in_req),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata),
    .o_accept          (w_accept),
    .o_valid           (w_valid),
    .o_timeout         (w_expire),
    .o_data            (w_data)
  );

  assign w_id_match = (w_data == EXPECTED_ID);
  assign w_ts_match = (w_data == EXPECTED_TIMESTAMP);

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_next   = r_state;
    w_start  = 1'b0;
    w_cap_id = 1'b0;
    w_cap_ts = 1'b0;
    w_set_to = 1'b0;
    w_end    = 1'b0;
`ifdef SYSID_VERIFY_RETRY_EN
    w_fail   = 1'b0;
    w_retry  = 1'b0;
`endif

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_start = 1'b1;
          w_next  = ID_REQ;
        end
      end
      ID_REQ, ID_WAIT: begin
        if (w_valid) begin
          w_cap_id = 1'b1;
          w_next   = TS_REQ;
        end else if (w_expire) begin
          w_set_to = 1'b1;
          w_end    = 1'b1;
        end else if ((r_state == ID_REQ) && w_accept) begin
          w_next = ID_WAIT;
        end
      end
      TS_REQ, TS_WAIT: begin
        if (w_valid) begin
          w_cap_ts = 1'b1;
          w_end    = 1'b1;
        end else if (w_expire) begin
          w_set_to = 1'b1;
          w_end    = 1'b1;
        end else if ((r_state == TS_REQ) && w_accept) begin
          w_next = TS_WAIT;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    if (w_end) begin
      w_next = DONE;
    end

`ifdef SYSID_VERIFY_RETRY_EN
    // The ID verdict is already registered; the TS verdict is this cycle's.
    w_fail = w_set_to | (w_cap_ts & ~(r_id_ok & w_ts_match));
    if (w_end && w_fail && (r_retry_cnt < 2'(MAX_RETRIES))) begin
      w_retry = 1'b1;
      w_next  = ID_REQ;
    end
`endif
  end

`ifdef SYSID_VERIFY_RETRY_EN
  assign w_enter_req = w_start | w_cap_id | w_retry;
  assign w_clear     = w_start | w_retry;
`else
  assign w_enter_req = w_start | w_cap_id;
  assign w_clear     = w_start;
`endif

  // Result registers; a new pass wipes the previous pass's results.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else if (w_clear) begin
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      if (w_cap_id) begin
        r_id_value <= w_data;
        r_id_ok    <= w_id_match;
      end
      if (w_cap_ts) begin
        r_ts_value <= w_data;
        r_ts_ok    <= w_ts_match;
      end
      if (w_set_to) begin
        r_timeout <= 1'b1;
      end
    end
  end

`ifdef SYSID_VERIFY_RETRY_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_retry_cnt <= '0;
    end else if (w_start) begin
      r_retry_cnt <= '0;
    end else if (w_retry) begin
      r_retry_cnt <= r_retry_cnt + 1'b1;
    end
  end

  assign retry_cnt = r_retry_cnt;
`endif

  // Address and read follow the state directly, so they stay put while the
  // slave stalls and drop on the edge that leaves a REQ state.
  assign avm_read    = w_in_req;
  assign avm_address = ((r_state == TS_REQ) || (r_state == TS_WAIT)) ? ADDR_TS : ADDR_ID;

  assign busy     = w_active;
  assign done     = (r_state == DONE);
  assign id_ok    = r_id_ok;
  assign ts_ok    = r_ts_ok;
  assign timeout  = r_timeout;
  assign id_value = r_id_value;
  assign ts_value = r_ts_value;

endmodule
